// File: rtl/pipeline_trace_monitor_if.sv
// Interface bundling the write-back observation bus and the trace read port
// of pipeline_trace_monitor.
//   master : the monitor (samples wb_*/br_*, presents rd_* head entry, takes rd_ready)
//   slave  : the CPU/consumer side (drives wb_*/br_*/rd_ready, observes rd_*)
// Signals:
//   wb_valid, wb_reg, wb_data  write-back stage observation
//   br_valid, br_target        taken branch at write-back
//   rd_ready                   consumer accepts head entry
//   rd_valid                   head entry available
//   rd_stamp, rd_wb_v, rd_reg, rd_data, rd_br_v, rd_target  head entry payload
interface pipeline_trace_monitor_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);
  logic              wb_valid;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              br_valid;
  logic [DATA_W-1:0] br_target;
  logic              rd_ready;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_stamp;
  logic              rd_wb_v;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic              rd_br_v;
  logic [DATA_W-1:0] rd_target;

  modport master (
    input  wb_valid, wb_reg, wb_data, br_valid, br_target, rd_ready,
    output rd_valid, rd_stamp, rd_wb_v, rd_reg, rd_data, rd_br_v, rd_target
  );

  modport slave (
    output wb_valid, wb_reg, wb_data, br_valid, br_target, rd_ready,
    input  rd_valid, rd_stamp, rd_wb_v, rd_reg, rd_data, rd_br_v, rd_target
  );
endinterface

// File: rtl/pipeline_trace_monitor.sv
// pipeline_trace_monitor: watches the CPU write-back stage, records
// write-back/branch events into a circular first-word-fall-through trace
// buffer, keeps cycle/stall/retire/drop statistics and declares DONE at a
// cycle limit or HUNG after a programmable idle window.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   enable        sampling enable (mirrors CPU enable)
//   stall         CPU stall indication
//   bus           pipeline_trace_monitor_if.master (wb/br inputs, rd_* read port)
//   cycle_count   enabled RUN cycles
//   stall_count   enabled RUN cycles with stall=1
//   retire_count  captured write-backs
//   drop_count    entries lost to overflow
//   overflow      sticky drop flag
//   done / hang   state is DONE / HUNG
// Optional feature macro: TRACE_SKIP_R0_EN -- write-backs to register 0 are
// ignored for capture, retire_count and the watchdog.
module pipeline_trace_monitor #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 50,
  parameter int WATCHDOG    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     stall,
  pipeline_trace_monitor_if.master bus,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         retire_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow,
  output logic                     done,
  output logic                     hang
);

  localparam int AW     = $clog2(DEPTH);
  localparam int IDLE_W = (WATCHDOG > 0) ? $clog2(WATCHDOG + 1) : 1;

  typedef enum logic [1:0] {S_RUN, S_DONE, S_HUNG} state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  stamp;
    logic              wb_v;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] data;
    logic              br_v;
    logic [DATA_W-1:0] target;
  } entry_t;

  state_t             state, state_next;
  entry_t             mem [DEPTH];
  entry_t             new_entry, head;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        occ;
  logic [IDLE_W-1:0]  idle_count, idle_inc;
  logic [CNT_W-1:0]   cycle_inc;
  logic               active, wb_eff, has_event;
  logic               full, has_data;
  logic               push_req, push, pop, drop;
  logic               hung_trig, done_trig;

`ifdef TRACE_SKIP_R0_EN
  assign wb_eff = bus.wb_valid && (bus.wb_reg != '0);
`else
  assign wb_eff = bus.wb_valid;
`endif

  assign active    = enable && (state == S_RUN);
  assign has_event = wb_eff || bus.br_valid;
  assign cycle_inc = cycle_count + CNT_W'(1);
  assign idle_inc  = idle_count + IDLE_W'(1);

  assign hung_trig = active && !has_event && (WATCHDOG != 0) &&
                     (idle_inc == IDLE_W'(WATCHDOG));
  assign done_trig = active && (CYCLE_LIMIT != 0) &&
                     (cycle_inc == CNT_W'(CYCLE_LIMIT));

  // Buffer control: a full buffer still accepts a push when the head is
  // popped on the same edge, so only push-without-pop into full drops.
  assign has_data = (occ != '0);
  assign full     = (occ == (AW+1)'(DEPTH));
  assign pop      = has_data && bus.rd_ready;
  assign push_req = active && has_event;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RUN;
    else        state <= state_next;
  end

  // Next-state logic; HUNG takes priority over DONE on the same edge
  always_comb begin
    state_next = state;
    if (hung_trig)      state_next = S_HUNG;
    else if (done_trig) state_next = S_DONE;
  end

  // Output decode
  always_comb begin
    done = 1'b0;
    hang = 1'b0;
    unique case (state)
      S_DONE:  done = 1'b1;
      S_HUNG:  hang = 1'b1;
      default: ;
    endcase
  end

  // Entry assembly; fields of an absent event stay zero
  always_comb begin
    new_entry       = '0;
    new_entry.stamp = cycle_count;
    if (wb_eff) begin
      new_entry.wb_v = 1'b1;
      new_entry.rg   = bus.wb_reg;
      new_entry.data = bus.wb_data;
    end
    if (bus.br_valid) begin
      new_entry.br_v   = 1'b1;
      new_entry.target = bus.br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // Head is gated by occupancy so the payload reads zero when empty,
  // including right after reset when storage contents are undefined.
  always_comb begin
    head = '0;
    if (has_data) head = mem[rd_ptr];
  end

  assign bus.rd_valid  = has_data;
  assign bus.rd_stamp  = head.stamp;
  assign bus.rd_wb_v   = head.wb_v;
  assign bus.rd_reg    = head.rg;
  assign bus.rd_data   = head.data;
  assign bus.rd_br_v   = head.br_v;
  assign bus.rd_target = head.target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count  <= '0;
      stall_count  <= '0;
      retire_count <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
      idle_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
    end else begin
      if (active) begin
        cycle_count <= cycle_inc;
        if (stall)  stall_count  <= stall_count + CNT_W'(1);
        if (wb_eff) retire_count <= retire_count + CNT_W'(1);
        idle_count <= has_event ? '0 : idle_inc;
      end
      if (drop) begin
        drop_count <= drop_count + CNT_W'(1);
        overflow   <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Directed self-checking bench for pipeline_trace_monitor with default
// parameters (DEPTH=16, CYCLE_LIMIT=50, WATCHDOG=16, 32-bit counters).
module tb_pipeline_trace_monitor;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        stall;
  logic [31:0] cycle_count, stall_count, retire_count, drop_count;
  logic        overflow, done, hang;
  int          n_cmp;
  int          n_bad;

  pipeline_trace_monitor_if #(.DATA_W(32), .REG_W(5), .CNT_W(32)) bus ();

  pipeline_trace_monitor #(
    .DATA_W(32), .REG_W(5), .DEPTH(16), .CNT_W(32),
    .CYCLE_LIMIT(50), .WATCHDOG(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .bus(bus),
    .cycle_count(cycle_count), .stall_count(stall_count),
    .retire_count(retire_count), .drop_count(drop_count),
    .overflow(overflow), .done(done), .hang(hang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: got still running want finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enable        = 1'b0;
    stall         = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_reg    = '0;
    bus.wb_data   = '0;
    bus.br_valid  = 1'b0;
    bus.br_target = '0;
    bus.rd_ready  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #2;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %0h want 0", bus.rd_valid); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_cycle: got %0d want 0", cycle_count); end
    n_cmp++; if ({overflow, done, hang} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {overflow, done, hang}); end
    n_cmp++; if (bus.rd_stamp !== 32'd0 || bus.rd_data !== 32'd0) begin n_bad++; $display("FAIL reset_payload: got %0h/%0h want 0/0", bus.rd_stamp, bus.rd_data); end
    do_reset();
    step();
    n_cmp++; if ({stall_count, retire_count, drop_count} !== 96'd0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", stall_count, retire_count, drop_count); end
  endtask

  // Three write-backs read out as they arrive (rd_ready held high)
  task automatic test_in_order();
    do_reset();
    enable = 1'b1;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'(3 + i);
      bus.wb_data  = 32'(10 + i);
      step();
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_stamp !== 32'(i)) begin n_bad++; $display("FAIL order_stamp%0d: got v=%0h s=%0d want v=1 s=%0d", i, bus.rd_valid, bus.rd_stamp, i); end
      n_cmp++; if (bus.rd_reg !== 5'(3 + i) || bus.rd_data !== 32'(10 + i) || bus.rd_wb_v !== 1'b1 || bus.rd_br_v !== 1'b0) begin n_bad++; $display("FAIL order_payload%0d: got r=%0d d=%0h wv=%0h bv=%0h want r=%0d d=%0h wv=1 bv=0", i, bus.rd_reg, bus.rd_data, bus.rd_wb_v, bus.rd_br_v, 3 + i, 10 + i); end
    end
    bus.wb_valid = 1'b0;
    step();
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL order_empty: got %0h want 0", bus.rd_valid); end
    n_cmp++; if (retire_count !== 32'd3 || cycle_count !== 32'd4) begin n_bad++; $display("FAIL order_counts: got ret=%0d cyc=%0d want ret=3 cyc=4", retire_count, cycle_count); end
  endtask

  // Branch-only entry and enable=0 hold
  task automatic test_branch_enable();
    do_reset();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd7;
    repeat (5) step();
    n_cmp++; if (cycle_count !== 32'd0 || bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL hold_disabled: got cyc=%0d v=%0h want cyc=0 v=0", cycle_count, bus.rd_valid); end
    enable = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'hDEAD_BEEF;
    step();
    bus.br_valid = 1'b0;
    enable = 1'b0;
    n_cmp++; if (bus.rd_br_v !== 1'b1 || bus.rd_target !== 32'hDEAD_BEEF || bus.rd_wb_v !== 1'b0) begin n_bad++; $display("FAIL branch_entry: got bv=%0h t=%0h wv=%0h want bv=1 t=deadbeef wv=0", bus.rd_br_v, bus.rd_target, bus.rd_wb_v); end
    n_cmp++; if (bus.rd_reg !== 5'd0 || bus.rd_data !== 32'd0 || retire_count !== 32'd0) begin n_bad++; $display("FAIL branch_zero: got r=%0d d=%0h ret=%0d want 0/0/0", bus.rd_reg, bus.rd_data, retire_count); end
    bus.rd_ready = 1'b1;
    step();
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL drain_disabled: got %0h want 0", bus.rd_valid); end
  endtask

  // 20 events into a 16-deep buffer with no reads
  task automatic test_overflow();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'(i);
      bus.wb_data  = 32'(256 + i);
      step();
    end
    bus.wb_valid = 1'b0;
    enable = 1'b0;
    n_cmp++; if (drop_count !== 32'd4 || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_drop: got drop=%0d ovf=%0h want drop=4 ovf=1", drop_count, overflow); end
    n_cmp++; if (retire_count !== 32'd20 || cycle_count !== 32'd20) begin n_bad++; $display("FAIL ovf_counts: got ret=%0d cyc=%0d want 20/20", retire_count, cycle_count); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_stamp !== 32'(i) || bus.rd_data !== 32'(256 + i)) begin n_bad++; $display("FAIL ovf_drain%0d: got v=%0h s=%0d d=%0h want v=1 s=%0d d=%0h", i, bus.rd_valid, bus.rd_stamp, bus.rd_data, i, 256 + i); end
      step();
    end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %0h want 0", bus.rd_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0h want 1", overflow); end
  endtask

  // Full buffer with simultaneous push and pop
  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_data  = 32'(512 + i);
      step();
    end
    bus.wb_data  = 32'h0000_0200;
    bus.rd_ready = 1'b1;
    step();
    bus.wb_valid = 1'b0;
    bus.rd_ready = 1'b0;
    enable = 1'b0;
    n_cmp++; if (drop_count !== 32'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_nodrop: got drop=%0d ovf=%0h want 0/0", drop_count, overflow); end
    n_cmp++; if (bus.rd_stamp !== 32'd1 || bus.rd_data !== 32'd513) begin n_bad++; $display("FAIL b2b_head: got s=%0d d=%0d want s=1 d=513", bus.rd_stamp, bus.rd_data); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_stamp !== 32'(i + 1)) begin n_bad++; $display("FAIL b2b_drain%0d: got v=%0h s=%0d want v=1 s=%0d", i, bus.rd_valid, bus.rd_stamp, i + 1); end
      if (i == 15) begin
        n_cmp++; if (bus.rd_data !== 32'h0000_0200) begin n_bad++; $display("FAIL b2b_last: got %0h want 200", bus.rd_data); end
      end
      step();
    end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %0h want 0", bus.rd_valid); end
  endtask

  // One event then 16 idle active cycles
  task automatic test_watchdog();
    do_reset();
    enable = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd1;
    bus.wb_data  = 32'h55;
    step();
    bus.wb_valid = 1'b0;
    repeat (15) step();
    n_cmp++; if (hang !== 1'b0) begin n_bad++; $display("FAIL wd_early: got %0h want 0", hang); end
    step();
    n_cmp++; if (hang !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL wd_hang: got hang=%0h done=%0h want 1/0", hang, done); end
    n_cmp++; if (cycle_count !== 32'd17) begin n_bad++; $display("FAIL wd_cycle: got %0d want 17", cycle_count); end
    bus.wb_valid = 1'b1;
    stall = 1'b1;
    repeat (5) step();
    bus.wb_valid = 1'b0;
    stall = 1'b0;
    n_cmp++; if (cycle_count !== 32'd17 || retire_count !== 32'd1 || stall_count !== 32'd0) begin n_bad++; $display("FAIL wd_frozen: got cyc=%0d ret=%0d st=%0d want 17/1/0", cycle_count, retire_count, stall_count); end
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h55) begin n_bad++; $display("FAIL wd_entry: got v=%0h d=%0h want v=1 d=55", bus.rd_valid, bus.rd_data); end
    bus.rd_ready = 1'b1;
    step();
    n_cmp++; if (bus.rd_valid !== 1'b0 || hang !== 1'b1) begin n_bad++; $display("FAIL wd_drain: got v=%0h hang=%0h want 0/1", bus.rd_valid, hang); end
  endtask

  // Continuous events up to the cycle limit, stall on 10 cycles
  task automatic test_cycle_limit();
    do_reset();
    enable = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd2;
    for (int i = 0; i < 50; i++) begin
      stall = (i < 10);
      step();
      if (i == 48) begin
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL lim_early: got %0h want 0", done); end
      end
    end
    stall = 1'b0;
    n_cmp++; if (done !== 1'b1 || hang !== 1'b0) begin n_bad++; $display("FAIL lim_done: got done=%0h hang=%0h want 1/0", done, hang); end
    n_cmp++; if (cycle_count !== 32'd50 || stall_count !== 32'd10) begin n_bad++; $display("FAIL lim_counts: got cyc=%0d st=%0d want 50/10", cycle_count, stall_count); end
    n_cmp++; if (retire_count !== 32'd50 || drop_count !== 32'd34) begin n_bad++; $display("FAIL lim_ret_drop: got ret=%0d drop=%0d want 50/34", retire_count, drop_count); end
    repeat (3) step();
    n_cmp++; if (cycle_count !== 32'd50 || drop_count !== 32'd34) begin n_bad++; $display("FAIL lim_frozen: got cyc=%0d drop=%0d want 50/34", cycle_count, drop_count); end
    bus.wb_valid = 1'b0;
  endtask

  // Asynchronous reset with buffered entries
  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_reg   = 5'd9;
      bus.wb_data  = 32'h1234;
      step();
    end
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h1234) begin n_bad++; $display("FAIL ar_before: got v=%0h d=%0h want 1/1234", bus.rd_valid, bus.rd_data); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0 || bus.rd_reg !== 5'd0) begin n_bad++; $display("FAIL ar_read: got v=%0h d=%0h r=%0d want 0/0/0", bus.rd_valid, bus.rd_data, bus.rd_reg); end
    n_cmp++; if (cycle_count !== 32'd0 || retire_count !== 32'd0) begin n_bad++; $display("FAIL ar_counts: got cyc=%0d ret=%0d want 0/0", cycle_count, retire_count); end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Register-0 write-back alongside a taken branch
  task automatic test_skip_r0();
    do_reset();
    enable = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_reg    = 5'd0;
    bus.wb_data   = 32'h77;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h400;
    step();
    bus.wb_valid = 1'b0;
    bus.br_valid = 1'b0;
    enable = 1'b0;
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_br_v !== 1'b1 || bus.rd_target !== 32'h400) begin n_bad++; $display("FAIL r0_branch: got v=%0h bv=%0h t=%0h want 1/1/400", bus.rd_valid, bus.rd_br_v, bus.rd_target); end
`ifdef TRACE_SKIP_R0_EN
    n_cmp++; if (bus.rd_wb_v !== 1'b0 || bus.rd_data !== 32'd0 || retire_count !== 32'd0) begin n_bad++; $display("FAIL r0_skip: got wv=%0h d=%0h ret=%0d want 0/0/0", bus.rd_wb_v, bus.rd_data, retire_count); end
`else
    n_cmp++; if (bus.rd_wb_v !== 1'b1 || bus.rd_data !== 32'h77 || retire_count !== 32'd1) begin n_bad++; $display("FAIL r0_keep: got wv=%0h d=%0h ret=%0d want 1/77/1", bus.rd_wb_v, bus.rd_data, retire_count); end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_in_order();
    test_branch_enable();
    test_overflow();
    test_back_to_back();
    test_watchdog();
    test_cycle_limit();
    test_async_reset();
    test_skip_r0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
